// File: rtl/ucsbece154b_fetch_buffer_if.sv
// Instruction-memory request/response bus between the fetch buffer (master)
// and instruction memory (slave). Signal suffixes are from the fetch buffer's side.
interface ucsbece154b_fetch_buffer_if;
  logic        ImemReqValid_o;
  logic        ImemReqReady_i;
  logic [31:0] ImemAddr_o;
  logic        ImemRespValid_i;
  logic [31:0] ImemRespData_i;

  modport master (
    output ImemReqValid_o,
    output ImemAddr_o,
    input  ImemReqReady_i,
    input  ImemRespValid_i,
    input  ImemRespData_i
  );

  modport slave (
    input  ImemReqValid_o,
    input  ImemAddr_o,
    output ImemReqReady_i,
    output ImemRespValid_i,
    output ImemRespData_i
  );
endinterface

// File: rtl/ucsbece154b_fetch_buffer.sv
// Fetch front end: in-order requests to a variable-latency imem, responses
// buffered with their PCs in a DEPTH-entry FIFO, flushed on EX redirect.
module ucsbece154b_fetch_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] PC_START  = 32'h00010000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  input  logic        StallF_i,
  output logic [31:0] InstrF_o,
  output logic [31:0] PCF_o,
  output logic [31:0] PCPlus4F_o,
  output logic        ValidF_o,
  ucsbece154b_fetch_buffer_if.master imem
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW-1:0] iw_q, iw_d, ir_q, ir_d;
  logic [AW:0] cnt_q, cnt_d, ocnt_q, ocnt_d, dcnt_q, dcnt_d;

  logic [31:0] finstr_q [DEPTH];
  logic [31:0] fpc_q    [DEPTH];
  logic [31:0] ipc_q    [DEPTH];

  logic [AW+1:0] occupancy;
  logic req_valid, hs, resp, drop, push, pop;

  assign occupancy = {1'b0, cnt_q} + {1'b0, ocnt_q};
  assign req_valid = !reset && !PCSrcE_i && (occupancy < DEPTH_W);
  assign hs        = req_valid && imem.ImemReqReady_i;
  // Responses with nothing in flight are spurious and ignored entirely.
  assign resp      = imem.ImemRespValid_i && (ocnt_q != '0);
  assign drop      = resp && (dcnt_q != '0);
  assign push      = resp && (dcnt_q == '0) && !PCSrcE_i;
  assign pop       = ValidF_o && !StallF_i && !PCSrcE_i;

  assign imem.ImemReqValid_o = req_valid;
  assign imem.ImemAddr_o     = pc_q;

  assign ValidF_o   = (cnt_q != '0);
  assign InstrF_o   = ValidF_o ? finstr_q[rptr_q] : NOP_INSTR;
  assign PCF_o      = ValidF_o ? fpc_q[rptr_q] : '0;
  assign PCPlus4F_o = ValidF_o ? fpc_q[rptr_q] + 32'd4 : '0;

  always_comb begin
    pc_d   = pc_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    dcnt_d = dcnt_q;
    iw_d   = hs   ? iw_q + AW'(1) : iw_q;
    ir_d   = resp ? ir_q + AW'(1) : ir_q;
    ocnt_d = ocnt_q + (AW+1)'(hs) - (AW+1)'(resp);
    if (PCSrcE_i) begin
      // Everything still in flight (minus a response consumed right now) is stale.
      pc_d   = PCTargetE_i & ~32'h3;
      rptr_d = wptr_q;
      cnt_d  = '0;
      dcnt_d = ocnt_q - (AW+1)'(resp);
    end else begin
      if (hs) pc_d = pc_q + 32'd4;
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop) rptr_d = rptr_q + AW'(1);
      cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      dcnt_d = dcnt_q - (AW+1)'(drop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= PC_START;
      wptr_q <= '0;
      rptr_q <= '0;
      iw_q   <= '0;
      ir_q   <= '0;
      cnt_q  <= '0;
      ocnt_q <= '0;
      dcnt_q <= '0;
    end else begin
      pc_q   <= pc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      iw_q   <= iw_d;
      ir_q   <= ir_d;
      cnt_q  <= cnt_d;
      ocnt_q <= ocnt_d;
      dcnt_q <= dcnt_d;
    end
  end

  // Storage needs no reset: contents are only observed through valid counts.
  always_ff @(posedge clk) begin
    if (hs) ipc_q[iw_q] <= pc_q;
    if (push) begin
      finstr_q[wptr_q] <= imem.ImemRespData_i;
      fpc_q[wptr_q]    <= ipc_q[ir_q];
    end
  end

endmodule

// File: tb/tb_ucsbece154b_fetch_buffer.sv
// Directed-vector bench for ucsbece154b_fetch_buffer; the bench plays the
// instruction memory by hand, one cycle per step.
module tb_ucsbece154b_fetch_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        ValidF;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  ucsbece154b_fetch_buffer_if bus();

  ucsbece154b_fetch_buffer #(
    .DEPTH(4),
    .PC_START(32'h00010000),
    .NOP_INSTR(32'h00000013)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PCSrcE_i(PCSrcE),
    .PCTargetE_i(PCTargetE),
    .StallF_i(StallF),
    .InstrF_o(InstrF),
    .PCF_o(PCF),
    .PCPlus4F_o(PCPlus4F),
    .ValidF_o(ValidF),
    .imem(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic resp(input logic v, input logic [31:0] d);
    bus.ImemRespValid_i = v;
    bus.ImemRespData_i  = d;
  endtask

  initial begin
    reset = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0;
    bus.ImemReqReady_i = 1'b0;
    resp(1'b0, '0);
    #1;
    chk("rst_valid", 32'(ValidF), 32'd0);
    chk("rst_instr", InstrF, 32'h00000013);
    chk("rst_pc", PCF, 32'h0);
    chk("rst_pc4", PCPlus4F, 32'h0);
    chk("rst_req", 32'(bus.ImemReqValid_o), 32'd0);
    tick(); tick();

    // Streaming, memory always ready, 1-cycle response latency
    reset = 1'b0; bus.ImemReqReady_i = 1'b1; settle();
    chk("s_req0", 32'(bus.ImemReqValid_o), 32'd1);
    chk("s_addr0", bus.ImemAddr_o, 32'h00010000);
    tick(); resp(1'b1, 32'hAB010000); settle();
    chk("s_valid_early", 32'(ValidF), 32'd0);
    chk("s_addr1", bus.ImemAddr_o, 32'h00010004);
    tick(); resp(1'b1, 32'hAB010004); settle();
    chk("s_valid", 32'(ValidF), 32'd1);
    chk("s_pc0", PCF, 32'h00010000);
    chk("s_instr0", InstrF, 32'hAB010000);
    chk("s_pc4_0", PCPlus4F, 32'h00010004);
    chk("s_addr2", bus.ImemAddr_o, 32'h00010008);
    tick(); resp(1'b1, 32'hAB010008); settle();
    chk("s_pc1", PCF, 32'h00010004);
    chk("s_instr1", InstrF, 32'hAB010004);
    chk("s_addr3", bus.ImemAddr_o, 32'h0001000C);
    tick(); resp(1'b1, 32'hAB01000C); bus.ImemReqReady_i = 1'b0; settle();
    chk("s_pc2", PCF, 32'h00010008);
    chk("s_instr2", InstrF, 32'hAB010008);
    chk("s_addr4_held", bus.ImemAddr_o, 32'h00010010);
    tick(); resp(1'b0, '0); settle();
    chk("s_pc3", PCF, 32'h0001000C);
    chk("s_instr3", InstrF, 32'hAB01000C);
    tick(); settle();
    chk("s_empty_valid", 32'(ValidF), 32'd0);
    chk("s_empty_instr", InstrF, 32'h00000013);
    chk("s_empty_pc", PCF, 32'h0);
    chk("s_empty_pc4", PCPlus4F, 32'h0);
    chk("s_addr4_still", bus.ImemAddr_o, 32'h00010010);

    // Stalled head: issue stops at DEPTH, resumes after first pop
    reset = 1'b1; settle();
    chk("st_rst_req", 32'(bus.ImemReqValid_o), 32'd0);
    tick(); reset = 1'b0; StallF = 1'b1; bus.ImemReqReady_i = 1'b1; settle();
    chk("st_addr0", bus.ImemAddr_o, 32'h00010000);
    tick(); resp(1'b1, 32'hAB010000); settle();
    chk("st_addr1", bus.ImemAddr_o, 32'h00010004);
    tick(); resp(1'b1, 32'hAB010004); settle();
    chk("st_req2", 32'(bus.ImemReqValid_o), 32'd1);
    chk("st_addr2", bus.ImemAddr_o, 32'h00010008);
    tick(); resp(1'b1, 32'hAB010008); settle();
    chk("st_addr3", bus.ImemAddr_o, 32'h0001000C);
    tick(); resp(1'b1, 32'hAB01000C); settle();
    chk("st_full_req", 32'(bus.ImemReqValid_o), 32'd0);
    tick(); resp(1'b0, '0); settle();
    chk("st_full_req2", 32'(bus.ImemReqValid_o), 32'd0);
    chk("st_head_pc", PCF, 32'h00010000);
    chk("st_head_instr", InstrF, 32'hAB010000);
    tick(); StallF = 1'b0; settle();
    chk("st_prepop_req", 32'(bus.ImemReqValid_o), 32'd0);
    tick(); settle();
    chk("st_resume_req", 32'(bus.ImemReqValid_o), 32'd1);
    chk("st_resume_addr", bus.ImemAddr_o, 32'h00010010);
    chk("st_next_pc", PCF, 32'h00010004);

    // Redirect with 3 outstanding; stale responses dropped
    reset = 1'b1; bus.ImemReqReady_i = 1'b0; tick();
    reset = 1'b0; bus.ImemReqReady_i = 1'b1; settle();
    chk("rd_addr0", bus.ImemAddr_o, 32'h00010000);
    tick(); settle(); tick(); settle();
    chk("rd_addr2", bus.ImemAddr_o, 32'h00010008);
    tick(); PCSrcE = 1'b1; PCTargetE = 32'h00002000; settle();
    chk("rd_req_gated", 32'(bus.ImemReqValid_o), 32'd0);
    tick(); PCSrcE = 1'b0; resp(1'b1, 32'h5EED0000); settle();
    chk("rd_valid_e", 32'(ValidF), 32'd0);
    chk("rd_new_addr", bus.ImemAddr_o, 32'h00002000);
    tick(); resp(1'b1, 32'h5EED0004); settle();
    chk("rd_valid_f", 32'(ValidF), 32'd0);
    tick(); resp(1'b1, 32'h5EED0008); settle();
    chk("rd_valid_g", 32'(ValidF), 32'd0);
    tick(); resp(1'b1, 32'hBB002000); bus.ImemReqReady_i = 1'b0; settle();
    chk("rd_valid_h", 32'(ValidF), 32'd0);
    chk("rd_addr_h", bus.ImemAddr_o, 32'h0000200C);
    tick(); resp(1'b0, '0); settle();
    chk("rd_head_valid", 32'(ValidF), 32'd1);
    chk("rd_head_pc", PCF, 32'h00002000);
    chk("rd_head_instr", InstrF, 32'hBB002000);

    // Redirect coinciding with a response and an unstalled pop
    PCSrcE = 1'b1; PCTargetE = 32'h00003006; resp(1'b1, 32'hBB002004); settle();
    tick(); PCSrcE = 1'b0; resp(1'b1, 32'hBB002008); settle();
    chk("rr_valid", 32'(ValidF), 32'd0);
    chk("rr_instr", InstrF, 32'h00000013);
    chk("rr_addr_aligned", bus.ImemAddr_o, 32'h00003004);
    tick(); resp(1'b0, '0); bus.ImemReqReady_i = 1'b1; settle();
    chk("rr_req", 32'(bus.ImemReqValid_o), 32'd1);
    chk("rr_valid_k", 32'(ValidF), 32'd0);
    tick(); bus.ImemReqReady_i = 1'b0; resp(1'b1, 32'hCC003004); settle();
    chk("rr_valid_l", 32'(ValidF), 32'd0);

    // Spurious responses with nothing outstanding
    tick(); StallF = 1'b1; resp(1'b1, 32'hDEADBEEF); settle();
    chk("rr_head_valid", 32'(ValidF), 32'd1);
    chk("rr_head_pc", PCF, 32'h00003004);
    chk("rr_head_pc4", PCPlus4F, 32'h00003008);
    chk("rr_head_instr", InstrF, 32'hCC003004);
    tick(); StallF = 1'b0; settle();
    chk("sp_head_pc", PCF, 32'h00003004);
    chk("sp_head_instr", InstrF, 32'hCC003004);
    tick(); settle();
    chk("sp_valid", 32'(ValidF), 32'd0);
    tick(); resp(1'b0, '0); bus.ImemReqReady_i = 1'b1; settle();
    chk("sp_valid2", 32'(ValidF), 32'd0);
    chk("sp_addr", bus.ImemAddr_o, 32'h00003008);

    // Reset mid-burst with 2 outstanding
    tick(); settle();
    chk("mr_addr1", bus.ImemAddr_o, 32'h0000300C);
    tick(); resp(1'b1, 32'hCC003008); settle();
    chk("mr_addr2", bus.ImemAddr_o, 32'h00003010);
    tick(); resp(1'b0, '0); bus.ImemReqReady_i = 1'b0; settle();
    chk("mr_pre_valid", 32'(ValidF), 32'd1);
    chk("mr_pre_pc", PCF, 32'h00003008);
    reset = 1'b1; settle();
    chk("mr_valid", 32'(ValidF), 32'd0);
    chk("mr_instr", InstrF, 32'h00000013);
    chk("mr_pc", PCF, 32'h0);
    chk("mr_pc4", PCPlus4F, 32'h0);
    chk("mr_req", 32'(bus.ImemReqValid_o), 32'd0);
    tick(); reset = 1'b0; resp(1'b1, 32'h0BADF00D); settle();
    chk("mr_restart_req", 32'(bus.ImemReqValid_o), 32'd1);
    chk("mr_restart_addr", bus.ImemAddr_o, 32'h00010000);
    tick(); resp(1'b0, '0); bus.ImemReqReady_i = 1'b1; settle();
    chk("mr_ignored", 32'(ValidF), 32'd0);
    tick(); bus.ImemReqReady_i = 1'b0; resp(1'b1, 32'hAB010000); settle();
    chk("mr_valid_v", 32'(ValidF), 32'd0);
    tick(); resp(1'b0, '0); settle();
    chk("mr_head_valid", 32'(ValidF), 32'd1);
    chk("mr_head_pc", PCF, 32'h00010000);
    chk("mr_head_instr", InstrF, 32'hAB010000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
